secure_router_rx: RTL and testbench

- Receive-side endpoint for one serial output lane of the secure router (data_out/strobe_out pair).
- Deserializes strobe-qualified bit frames back into parallel payload words.
- Checks even parity and framing, and buffers good words in a small FIFO with a valid/ready handshake toward the consuming logic.
- Reports errors as 1-cycle pulses and a saturating counter.

---
 rtl/secure_router_rx_if.sv | 10 +
 rtl/secure_router_rx.sv | 132 +++++++++++++
 tb/tb_secure_router_rx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/secure_router_rx_if.sv
// secure_router_rx_if: valid/ready word stream from the lane receiver to its consumer.
interface secure_router_rx_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/secure_router_rx.sv
// secure_router_rx: deserializes strobe-qualified parity frames into a FWFT FIFO,
// reporting parity, framing and overflow errors as pulses plus a saturating count.
module secure_router_rx #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_in,
    input  logic                 strobe_in,
    secure_router_rx_if.master   out_if,
    output logic                 par_err,
    output logic                 frame_err,
    output logic                 drop,
    output logic [CNT_W-1:0]     err_count
);
    localparam int CW = $clog2(DATA_W + 2);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W:0]     sr_q, sr_d;
    logic                excess_q, excess_d;
    logic                par_err_q, par_err_d;
    logic                frame_err_q, frame_err_d;
    logic                drop_q, drop_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH], mem_d [FIFO_DEPTH];
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]         fill_q, fill_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                done, good, full, pop, push;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        excess_d    = excess_q;
        frame_err_d = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: if (strobe_in) begin
                sr_d    = {{DATA_W{1'b0}}, data_in};
                cnt_d   = CW'(1);
                state_d = SHIFT;
            end
            SHIFT: if (strobe_in) begin
                sr_d  = {sr_q[DATA_W-1:0], data_in};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_W)) begin
                    done     = 1'b1;
                    excess_d = 1'b0;
                    state_d  = DRAIN;
                end
            end else begin
                frame_err_d = 1'b1;
                cnt_d       = '0;
                sr_d        = '0;
                state_d     = IDLE;
            end
            DRAIN: if (strobe_in) begin
                // Only the first overrun bit is reported; the frame already landed.
                frame_err_d = !excess_q;
                excess_d    = 1'b1;
            end else begin
                cnt_d    = '0;
                excess_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        full        = fill_q == (AW+1)'(FIFO_DEPTH);
        pop         = out_if.out_valid && out_if.out_ready;
        good        = done && !(^sr_d);
        par_err_d   = done && (^sr_d);
        push        = good && (!full || pop);
        drop_d      = good && full && !pop;
        mem_d       = mem_q;
        if (push) mem_d[wr_q] = sr_d[DATA_W:1];
        wr_d        = wr_q + AW'(push);
        rd_d        = rd_q + AW'(pop);
        fill_d      = fill_q + (AW+1)'(push) - (AW+1)'(pop);
        hold_d      = pop ? mem_q[rd_q] : hold_q;
        err_count_d = ((par_err_d || frame_err_d || drop_d) && err_count_q != '1) ? err_count_q + CNT_W'(1) : err_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            excess_q    <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            drop_q      <= 1'b0;
            err_count_q <= '0;
            mem_q       <= '{default: '0};
            wr_q        <= '0;
            rd_q        <= '0;
            fill_q      <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            excess_q    <= excess_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            drop_q      <= drop_d;
            err_count_q <= err_count_d;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            fill_q      <= fill_d;
            hold_q      <= hold_d;
        end
    end

    // Empty FIFO shows the last word popped so out_data stays stable.
    assign out_if.out_valid = fill_q != '0;
    assign out_if.out_data  = out_if.out_valid ? mem_q[rd_q] : hold_q;
    assign par_err          = par_err_q;
    assign frame_err        = frame_err_q;
    assign drop             = drop_q;
    assign err_count        = err_count_q;
endmodule

// File: tb/tb_secure_router_rx.sv
// tb_secure_router_rx: directed checks of framing, parity, FIFO backpressure,
// overrun, async reset and counter saturation.
module tb_secure_router_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_in = 1'b0;
    logic       strobe_in = 1'b0;
    logic       par_err, frame_err, drop;
    logic [7:0] err_count;
    int         checks = 0;
    int         errors = 0;

    secure_router_rx_if #(.DATA_W(4)) bus ();

    secure_router_rx #(.DATA_W(4), .FIFO_DEPTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .strobe_in (strobe_in),
        .out_if    (bus.master),
        .par_err   (par_err),
        .frame_err (frame_err),
        .drop      (drop),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        strobe_in = 1'b1;
        data_in   = b;
        tick();
    endtask

    task automatic gap();
        strobe_in = 1'b0;
        data_in   = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [4:0] f);
        for (int i = 4; i >= 0; i--) send_bit(f[i]);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_cnt", 32'(err_count), 0);
        chk("rst_pulses", 32'({par_err, frame_err, drop}), 0);
        rst_n = 1'b1;
        tick();

        send_frame(5'b10111);
        chk("good_valid", 32'(bus.out_valid), 1);
        chk("good_data", 32'(bus.out_data), 32'hB);
        gap();
        chk("good_popped", 32'(bus.out_valid), 0);
        chk("good_hold", 32'(bus.out_data), 32'hB);
        chk("good_cnt", 32'(err_count), 0);

        send_frame(5'b10110);
        chk("par_pulse", 32'(par_err), 1);
        chk("par_valid", 32'(bus.out_valid), 0);
        chk("par_cnt", 32'(err_count), 1);
        gap();
        chk("par_once", 32'(par_err), 0);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        gap();
        chk("short_pulse", 32'(frame_err), 1);
        chk("short_cnt", 32'(err_count), 2);
        send_frame(5'b01100);
        chk("short_once", 32'(frame_err), 0);
        chk("after_short_valid", 32'(bus.out_valid), 1);
        chk("after_short_data", 32'(bus.out_data), 32'h6);
        gap();

        bus.out_ready = 1'b0;
        send_frame(5'b00011);
        gap();
        send_frame(5'b00101);
        chk("bp_nodrop", 32'(drop), 0);
        gap();
        send_frame(5'b00110);
        chk("bp_drop", 32'(drop), 1);
        chk("bp_cnt", 32'(err_count), 3);
        chk("bp_head", 32'(bus.out_data), 32'h1);
        gap();
        chk("bp_drop_once", 32'(drop), 0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_second_valid", 32'(bus.out_valid), 1);
        chk("bp_second", 32'(bus.out_data), 32'h2);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 0);

        send_frame(5'b11000);
        chk("long_valid", 32'(bus.out_valid), 1);
        chk("long_data", 32'(bus.out_data), 32'hC);
        chk("long_no_err_yet", 32'(frame_err), 0);
        send_bit(1'b1);
        chk("long_pulse", 32'(frame_err), 1);
        chk("long_cnt", 32'(err_count), 4);
        send_bit(1'b0);
        chk("long_once", 32'(frame_err), 0);
        gap();
        chk("long_cnt_final", 32'(err_count), 4);
        chk("long_popped", 32'(bus.out_valid), 0);

        bus.out_ready = 1'b0;
        send_frame(5'b10100);
        gap();
        chk("mid_held", 32'(bus.out_valid), 1);
        send_bit(1'b1);
        send_bit(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.out_valid), 0);
        chk("async_data", 32'(bus.out_data), 0);
        chk("async_cnt", 32'(err_count), 0);
        strobe_in = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        send_frame(5'b10100);
        chk("post_rst_valid", 32'(bus.out_valid), 1);
        chk("post_rst_data", 32'(bus.out_data), 32'hA);
        chk("post_rst_cnt", 32'(err_count), 0);
        gap();

        for (int i = 0; i < 259; i++) begin
            send_frame(5'b00001);
            gap();
            if (i == 253) chk("sat_minus1", 32'(err_count), 32'hFE);
            if (i == 254) chk("sat_reach", 32'(err_count), 32'hFF);
        end
        chk("sat_hold", 32'(err_count), 32'hFF);
        chk("sat_no_valid", 32'(bus.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
